// File: rtl/instruction_memory_pkg.sv
// ---------------------------------------------------------------------------
// instruction_memory_pkg
// Shared constants for the IF-stage instruction memory and the program
// counter defaults: default sizes, the NOP encoding returned for unloaded
// or out-of-range addresses, and the byte-to-word packing factor.
// ---------------------------------------------------------------------------
package instruction_memory_pkg;

   localparam int DEFAULT_PC_SIZE        = 32;
   localparam int DEFAULT_INST_MEM_WORDS = 64;
   localparam int DEFAULT_WORD_SIZE      = 32;
   localparam int DEFAULT_BYTE_SIZE      = 8;
   localparam int BYTES_PER_WORD         = 4;

   // sll $0,$0,0 -- the all-zero word is a harmless NOP
   localparam logic [31:0] INST_NOP = 32'h0000_0000;

   // Width of a counter that must hold 0..words inclusive
   function automatic int count_width(input int words);
      return $clog2(words) + 1;
   endfunction

endpackage

// File: rtl/instruction_memory_if.sv
// ---------------------------------------------------------------------------
// instruction_memory_if
// Bus between the instruction memory and its clients (debug loader and PC).
//   i_clear       program clear (empties memory logically)
//   i_inst_write  byte strobe from the debug loader
//   i_inst_byte   load byte, most significant byte of the word first
//   i_pc          byte address from the program counter
//   o_instruction instruction word at i_pc (combinational)
//   o_full        memory holds MEM_SIZE_WORDS words
//   o_empty       memory holds no words
//   o_word_count  number of complete words loaded
// master: the client side (drives the i_* signals)
// slave : the memory side (drives the o_* signals)
// ---------------------------------------------------------------------------
interface instruction_memory_if
   import instruction_memory_pkg::*;
#(
   parameter int PC_SIZE        = DEFAULT_PC_SIZE,
   parameter int WORD_SIZE      = DEFAULT_WORD_SIZE,
   parameter int BYTE_SIZE      = DEFAULT_BYTE_SIZE,
   parameter int MEM_SIZE_WORDS = DEFAULT_INST_MEM_WORDS
);

   localparam int CNT_W = count_width(MEM_SIZE_WORDS);

   logic                 i_clear;
   logic                 i_inst_write;
   logic [BYTE_SIZE-1:0] i_inst_byte;
   logic [PC_SIZE-1:0]   i_pc;
   logic [WORD_SIZE-1:0] o_instruction;
   logic                 o_full;
   logic                 o_empty;
   logic [CNT_W-1:0]     o_word_count;

   modport master (
      output i_clear, i_inst_write, i_inst_byte, i_pc,
      input  o_instruction, o_full, o_empty, o_word_count
   );

   modport slave (
      input  i_clear, i_inst_write, i_inst_byte, i_pc,
      output o_instruction, o_full, o_empty, o_word_count
   );

endinterface

// File: rtl/instruction_memory_assembler.sv
// ---------------------------------------------------------------------------
// inst_byte_assembler
// Packs a big-endian byte stream into words. The first three bytes of a word
// are held in an assembly register; the fourth byte is combined with them and
// presented together with a one-cycle o_word_valid in the same cycle, so the
// parent commits the word on that very edge.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_clear          synchronous clear, discards a partial word
//   i_enable         accept i_byte this cycle (already gated by the parent)
//   i_byte           incoming byte
//   o_word_valid     complete word available this cycle
//   o_word           {assembled bytes, i_byte}
// ---------------------------------------------------------------------------
module inst_byte_assembler
   import instruction_memory_pkg::*;
#(
   parameter int BYTE_SIZE = DEFAULT_BYTE_SIZE,
   parameter int WORD_SIZE = DEFAULT_WORD_SIZE
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_clear,
   input  logic                 i_enable,
   input  logic [BYTE_SIZE-1:0] i_byte,
   output logic                 o_word_valid,
   output logic [WORD_SIZE-1:0] o_word
);

   localparam int ASM_W = WORD_SIZE - BYTE_SIZE;
   localparam int IDX_W = $clog2(BYTES_PER_WORD);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

   logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
   logic [ASM_W-1:0] asm_q, asm_d;

   always_comb begin
      byte_idx_d   = byte_idx_q;
      asm_d        = asm_q;
      o_word_valid = 1'b0;
      o_word       = {asm_q, i_byte};
      if (i_enable) begin
         if (byte_idx_q == LAST_IDX) begin
            o_word_valid = 1'b1;
            byte_idx_d   = '0;
            asm_d        = '0;
         end else begin
            // byte k lands in slot (3-k): first byte ends up most significant
            asm_d[ASM_W-1 - int'(byte_idx_q)*BYTE_SIZE -: BYTE_SIZE] = i_byte;
            byte_idx_d = byte_idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         byte_idx_q <= '0;
         asm_q      <= '0;
      end else begin
         byte_idx_q <= byte_idx_d;
         asm_q      <= asm_d;
      end
   end

endmodule

// File: rtl/instruction_memory.sv
// ---------------------------------------------------------------------------
// instruction_memory
// IF-stage instruction memory. The debug unit loads the program one byte per
// cycle (MSB first); every four bytes form one word appended at the write
// pointer. The PC reads the word at its byte address combinationally; any
// word not yet loaded, or beyond the array, reads as NOP.
// Ports:
//   i_clk    clock, all state updates on the rising edge
//   i_reset  synchronous active-high reset (array contents are kept)
//   bus      instruction_memory_if.slave: clear, byte strobe/data, PC,
//            instruction, full/empty flags and word count
// ---------------------------------------------------------------------------
module instruction_memory
   import instruction_memory_pkg::*;
#(
   parameter int PC_SIZE        = DEFAULT_PC_SIZE,
   parameter int WORD_SIZE      = DEFAULT_WORD_SIZE,
   parameter int BYTE_SIZE      = DEFAULT_BYTE_SIZE,
   parameter int MEM_SIZE_WORDS = DEFAULT_INST_MEM_WORDS
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   instruction_memory_if.slave   bus
);

   localparam int AW    = $clog2(MEM_SIZE_WORDS);
   localparam int CNT_W = count_width(MEM_SIZE_WORDS);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MEM_SIZE_WORDS);

   logic [WORD_SIZE-1:0] mem_q [MEM_SIZE_WORDS];
   logic [CNT_W-1:0]     wr_ptr_q, wr_ptr_d;

   logic                 full;
   logic                 load_en;
   logic                 word_valid;
   logic [WORD_SIZE-1:0] word;

   logic [PC_SIZE-1:0]   pc_word;
   logic [AW-1:0]        rd_idx;
   logic                 rd_hit;

   assign full = (wr_ptr_q == FULL_CNT);

   // Strobes are dropped while full, and under reset/clear so that nothing
   // is committed on the edge that empties the memory.
   assign load_en = bus.i_inst_write && !full && !i_reset && !bus.i_clear;

   inst_byte_assembler #(
      .BYTE_SIZE (BYTE_SIZE),
      .WORD_SIZE (WORD_SIZE)
   ) u_asm (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_clear      (bus.i_clear),
      .i_enable     (load_en),
      .i_byte       (bus.i_inst_byte),
      .o_word_valid (word_valid),
      .o_word       (word)
   );

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      if (word_valid) wr_ptr_d = wr_ptr_q + 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset || bus.i_clear) wr_ptr_q <= '0;
      else                        wr_ptr_q <= wr_ptr_d;
   end

   // Array has no reset: stale contents are hidden by the wr_ptr gate below.
   always_ff @(posedge i_clk) begin
      if (word_valid) mem_q[wr_ptr_q[AW-1:0]] <= word;
   end

   // Full-width word-address compare: because wr_ptr never exceeds the depth,
   // this also rejects out-of-range PCs instead of letting the index alias.
   assign pc_word = bus.i_pc >> 2;
   assign rd_idx  = bus.i_pc[AW+1:2];
   assign rd_hit  = (pc_word < PC_SIZE'(wr_ptr_q));

   assign bus.o_instruction = rd_hit ? mem_q[rd_idx] : WORD_SIZE'(INST_NOP);
   assign bus.o_full        = full;
   assign bus.o_empty       = (wr_ptr_q == '0);
   assign bus.o_word_count  = wr_ptr_q;

endmodule

// File: tb/tb_instruction_memory.sv
module tb_instruction_memory;
   import instruction_memory_pkg::*;

   localparam int MEMW = 64;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   instruction_memory_if #(
      .PC_SIZE(32), .WORD_SIZE(32), .BYTE_SIZE(8), .MEM_SIZE_WORDS(MEMW)
   ) bus ();

   instruction_memory #(
      .PC_SIZE(32), .WORD_SIZE(32), .BYTE_SIZE(8), .MEM_SIZE_WORDS(MEMW)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] word;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      logic [31:0] pc;
      logic [31:0] exp;
   } rd_vec_t;

   // reference state for the byte loader
   int          m_bidx = 0;
   logic [23:0] m_asm  = '0;
   int          m_wptr = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_check(input string name, input logic [31:0] pc, input logic [31:0] exp);
      bus.i_pc = pc;
      #1;
      check(name, bus.o_instruction, exp);
   endtask

   task automatic status_check(input string tag);
      check({tag, "_count"}, 32'(bus.o_word_count), 32'(m_wptr));
      check({tag, "_empty"}, 32'(bus.o_empty), 32'(m_wptr == 0));
      check({tag, "_full"},  32'(bus.o_full),  32'(m_wptr == MEMW));
   endtask

   task automatic model_clear();
      m_bidx = 0;
      m_asm  = '0;
      m_wptr = 0;
      sb_q.delete();
   endtask

   task automatic strobe(input logic [7:0] b);
      bus.i_inst_write = 1'b1;
      bus.i_inst_byte  = b;
      if (m_wptr < MEMW) begin
         if (m_bidx < 3) begin
            m_asm[23 - 8*m_bidx -: 8] = b;
            m_bidx++;
         end else begin
            sb_q.push_back('{addr: 32'(m_wptr * 4), word: {m_asm, b}});
            m_wptr++;
            m_bidx = 0;
            m_asm  = '0;
         end
      end
      tick();
      bus.i_inst_write = 1'b0;
   endtask

   task automatic strobe_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) strobe(w[31 - 8*i -: 8]);
   endtask

   task automatic drain();
      sb_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         read_check("sb_word", e.addr, e.word);
      end
   endtask

   rd_vec_t rv[6];

   initial begin
      bus.i_clear      = 1'b0;
      bus.i_inst_write = 1'b0;
      bus.i_inst_byte  = '0;
      bus.i_pc         = '0;

      // reset state
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      model_clear();
      read_check("rst_pc0", 32'h0, 32'h0);
      read_check("rst_pc10", 32'h10, 32'h0);
      status_check("rst");

      // first word; completing word still reads NOP before its edge
      strobe(8'h20);
      strobe(8'h08);
      strobe(8'h00);
      bus.i_pc         = 32'h0;
      bus.i_inst_write = 1'b1;
      bus.i_inst_byte  = 8'h05;
      #1;
      check("pending_word_nop", bus.o_instruction, 32'h0);
      check("pending_count", 32'(bus.o_word_count), 32'd0);
      strobe(8'h05);
      drain();
      status_check("one_word");

      rv[0] = '{pc: 32'h0,        exp: 32'h2008_0005};
      rv[1] = '{pc: 32'h3,        exp: 32'h2008_0005};
      rv[2] = '{pc: 32'h1,        exp: 32'h2008_0005};
      rv[3] = '{pc: 32'h4,        exp: 32'h0};
      rv[4] = '{pc: 32'h100,      exp: 32'h0};
      rv[5] = '{pc: 32'hFFFF_FFFC, exp: 32'h0};
      for (int i = 0; i < 6; i++) read_check($sformatf("vec%0d", i), rv[i].pc, rv[i].exp);

      // fill the whole memory with word k = k
      bus.i_clear = 1'b1;
      tick();
      bus.i_clear = 1'b0;
      model_clear();
      status_check("clr1");
      for (int k = 0; k < MEMW; k++) strobe_word(32'(k));
      drain();
      status_check("full");
      read_check("full_pcFC", 32'hFC, 32'd63);
      for (int i = 0; i < 4; i++) strobe(8'hFF);
      check("full_sb_empty", 32'(sb_q.size()), 32'd0);
      status_check("full_ovf");
      read_check("full_pc100", 32'h100, 32'h0);
      read_check("full_pc104", 32'h104, 32'h0);
      read_check("full_pcFC_kept", 32'hFC, 32'd63);
      read_check("full_pc4_kept", 32'h4, 32'd1);

      // clear mid-word discards partial bytes
      bus.i_clear = 1'b1;
      tick();
      bus.i_clear = 1'b0;
      model_clear();
      strobe(8'hAA);
      strobe(8'hBB);
      read_check("partial_unreadable", 32'h0, 32'h0);
      bus.i_clear = 1'b1;
      tick();
      bus.i_clear = 1'b0;
      model_clear();
      status_check("clr_mid");
      strobe_word(32'h1122_3344);
      drain();
      status_check("after_clr_mid");

      // clear and strobe together with 3 bytes pending
      bus.i_clear = 1'b1;
      tick();
      bus.i_clear = 1'b0;
      model_clear();
      strobe(8'h55);
      strobe(8'h66);
      strobe(8'h77);
      bus.i_clear      = 1'b1;
      bus.i_inst_write = 1'b1;
      bus.i_inst_byte  = 8'h88;
      tick();
      bus.i_clear      = 1'b0;
      bus.i_inst_write = 1'b0;
      model_clear();
      status_check("clr_strobe");
      read_check("clr_strobe_pc0", 32'h0, 32'h0);
      strobe_word(32'h0102_0304);
      drain();
      status_check("after_clr_strobe");

      // reset with a byte strobe present
      strobe_word(32'hDEAD_BEEF);
      drain();
      status_check("two_words");
      rst              = 1'b1;
      bus.i_inst_write = 1'b1;
      bus.i_inst_byte  = 8'h99;
      tick();
      rst              = 1'b0;
      bus.i_inst_write = 1'b0;
      model_clear();
      status_check("rst_strobe");
      read_check("rst_strobe_pc0", 32'h0, 32'h0);
      read_check("rst_strobe_pc4", 32'h4, 32'h0);
      strobe_word(32'hCAFE_F00D);
      drain();
      status_check("after_rst_strobe");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
